// File: rtl/inertial_pulse_filter.sv
// -----------------------------------------------------------------------------
// inertial_pulse_filter
//
// Clocked model of gate inertial delay for a notif1 data/control pair. Each of
// the two independent channels forwards a change of its raw input only once
// the change has persisted for DELAY sampled edges. Shorter pulses are
// swallowed and counted in a saturating per-channel rejection counter.
//
// Parameters
//   DELAY     minimum persistence in cycles for a change to propagate (1..255)
//   CW        width of the rejection counters
//   CTRL_RST  reset value of ctrl_o
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   inp       raw data input
//   ctrl      raw enable input
//   rej_clr   synchronous clear of both rejection counters (wins over a
//             rejection on the same edge)
//   inp_o     filtered data (notif1 data)
//   ctrl_o    filtered enable (notif1 control)
//   busy      high while either channel is waiting out a pending change
//   inp_rej   saturating count of rejected data pulses
//   ctrl_rej  saturating count of rejected enable pulses
// -----------------------------------------------------------------------------
module inertial_pulse_filter #(
   parameter int unsigned DELAY    = 4,
   parameter int unsigned CW       = 8,
   parameter logic        CTRL_RST = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inp,
   input  logic          ctrl,
   input  logic          rej_clr,
   output logic          inp_o,
   output logic          ctrl_o,
   output logic          busy,
   output logic [CW-1:0] inp_rej,
   output logic [CW-1:0] ctrl_rej
);

   typedef enum logic {
      STABLE  = 1'b0,
      PENDING = 1'b1
   } state_t;

   // The edge that first sees the change already counts as one cycle, and the
   // commit happens on the edge where cnt is zero, hence DELAY-2.
   localparam logic [7:0] CNT_INIT = (DELAY > 1) ? 8'(DELAY - 2) : 8'd0;
   // Index 0 is the data channel, index 1 the enable channel.
   localparam logic [1:0] Q_RST    = {CTRL_RST, 1'b0};

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : v + CW'(1);
   endfunction

   logic [1:0]    raw;
   logic [1:0]    q;
   logic [1:0]    q_nxt;
   state_t        state     [2];
   state_t        state_nxt [2];
   logic [7:0]    cnt       [2];
   logic [7:0]    cnt_nxt   [2];
   logic [CW-1:0] rej       [2];
   logic [CW-1:0] rej_nxt   [2];

   assign raw = {ctrl, inp};

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= Q_RST;
         for (int i = 0; i < 2; i++) begin
            state[i] <= STABLE;
            cnt[i]   <= 8'd0;
            rej[i]   <= '0;
         end
      end else begin
         q <= q_nxt;
         for (int i = 0; i < 2; i++) begin
            state[i] <= state_nxt[i];
            cnt[i]   <= cnt_nxt[i];
            rej[i]   <= rej_nxt[i];
         end
      end
   end

   always_comb begin
      q_nxt = q;
      for (int i = 0; i < 2; i++) begin
         state_nxt[i] = state[i];
         cnt_nxt[i]   = cnt[i];
         rej_nxt[i]   = rej[i];
         case (state[i])
            STABLE: begin
               if (raw[i] != q[i]) begin
                  if (DELAY == 1) begin
                     q_nxt[i] = raw[i];
                  end else begin
                     cnt_nxt[i]   = CNT_INIT;
                     state_nxt[i] = PENDING;
                  end
               end
            end
            PENDING: begin
               // q is one bit, so raw == q means the pulse ended early.
               if (raw[i] == q[i]) begin
                  rej_nxt[i]   = sat_inc(rej[i]);
                  state_nxt[i] = STABLE;
               end else if (cnt[i] == 8'd0) begin
                  q_nxt[i]     = raw[i];
                  state_nxt[i] = STABLE;
               end else begin
                  cnt_nxt[i] = cnt[i] - 8'd1;
               end
            end
            default: state_nxt[i] = STABLE;
         endcase
         if (rej_clr) begin
            rej_nxt[i] = '0;
         end
      end
   end

   assign inp_o    = q[0];
   assign ctrl_o   = q[1];
   assign busy     = (state[0] == PENDING) | (state[1] == PENDING);
   assign inp_rej  = rej[0];
   assign ctrl_rej = rej[1];

endmodule
